// File: rtl/riscv_pkg.sv
// Shared core types: machine word width and the memory arbiter FSM encoding.
package riscv_pkg;

  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_IF = 2'd1,
    BUSY_DM = 2'd2
  } arb_state_t;

endpackage

// File: rtl/memory_arbiter.sv
// Shares one single-port memory between fetch and data ports; data wins, fetch waits at most MAX_DM_STREAK grants.
// Latency >= 2 cycles request-to-valid; ports hold req until their valid pulse and see stall_F/stall_M meanwhile.
module memory_arbiter
  import riscv_pkg::*;
#(
  parameter int ADDR_W        = XLEN,
  parameter int DATA_W        = XLEN,
  parameter int MAX_DM_STREAK = 4
) (
  input  logic              clk,
  input  logic              rst_n,

  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_abort,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_valid,
  output logic              stall_F,

  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_valid,
  output logic              stall_M,

  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready
);

  localparam int SW = $clog2(MAX_DM_STREAK + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_DM_STREAK);

  arb_state_t        state_q, state_d;
  logic [SW-1:0]     streak_q, streak_d;
  logic              abort_pend_q, abort_pend_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              we_q, we_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              if_valid_q, if_valid_d;
  logic              dm_valid_q, dm_valid_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;

  // A port whose valid is pulsing still holds its old req; masking it stops a duplicate grant.
  logic if_elig, dm_elig, grant_dm, grant_if;

  assign if_elig  = if_req & ~if_valid_q;
  assign dm_elig  = dm_req & ~dm_valid_q;
  assign grant_dm = dm_elig & (~if_elig | (streak_q != STREAK_MAX));
  assign grant_if = if_elig & ~grant_dm;

  always_comb begin
    state_d      = state_q;
    streak_d     = streak_q;
    abort_pend_d = abort_pend_q;
    addr_d       = addr_q;
    we_d         = we_q;
    wdata_d      = wdata_q;
    if_valid_d   = 1'b0;
    dm_valid_d   = 1'b0;
    if_rdata_d   = if_rdata_q;
    dm_rdata_d   = dm_rdata_q;

    case (state_q)
      IDLE: begin
        abort_pend_d = 1'b0;
        if (grant_dm) begin
          state_d = BUSY_DM;
          addr_d  = dm_addr;
          we_d    = dm_we;
          wdata_d = dm_wdata;
          if (!if_req) begin
            streak_d = '0;
          end else if (streak_q != STREAK_MAX) begin
            streak_d = streak_q + 1'b1;
          end
        end else if (grant_if) begin
          state_d  = BUSY_IF;
          addr_d   = if_addr;
          we_d     = 1'b0;
          streak_d = '0;
        end
      end

      BUSY_IF: begin
        if (if_abort) begin
          abort_pend_d = 1'b1;
        end
        if (mem_ready) begin
          state_d      = IDLE;
          abort_pend_d = 1'b0;
          // An abort in the completing cycle itself must also swallow the result.
          if (!(abort_pend_q | if_abort)) begin
            if_valid_d = 1'b1;
            if_rdata_d = mem_rdata;
          end
        end
      end

      BUSY_DM: begin
        if (mem_ready) begin
          state_d    = IDLE;
          dm_valid_d = 1'b1;
          if (!we_q) begin
            dm_rdata_d = mem_rdata;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      streak_q     <= '0;
      abort_pend_q <= 1'b0;
      addr_q       <= '0;
      we_q         <= 1'b0;
      wdata_q      <= '0;
      if_valid_q   <= 1'b0;
      dm_valid_q   <= 1'b0;
      if_rdata_q   <= '0;
      dm_rdata_q   <= '0;
    end else begin
      state_q      <= state_d;
      streak_q     <= streak_d;
      abort_pend_q <= abort_pend_d;
      addr_q       <= addr_d;
      we_q         <= we_d;
      wdata_q      <= wdata_d;
      if_valid_q   <= if_valid_d;
      dm_valid_q   <= dm_valid_d;
      if_rdata_q   <= if_rdata_d;
      dm_rdata_q   <= dm_rdata_d;
    end
  end

  assign mem_req   = (state_q != IDLE);
  assign mem_we    = (state_q == BUSY_DM) & we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

  assign if_valid  = if_valid_q;
  assign dm_valid  = dm_valid_q;
  assign if_rdata  = if_rdata_q;
  assign dm_rdata  = dm_rdata_q;

  assign stall_F   = if_req & ~if_valid_q;
  assign stall_M   = dm_req & ~dm_valid_q;

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed bench for memory_arbiter: vector table of single accesses plus multi-cycle corner sequences.
module tb_memory_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req, if_abort, if_valid, stall_F;
  logic [31:0] if_addr, if_rdata;
  logic        dm_req, dm_we, dm_valid, stall_M;
  logic [31:0] dm_addr, dm_wdata, dm_rdata;
  logic        mem_req, mem_we, mem_ready;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  int total = 0;
  int bad   = 0;
  int lat   = 1;
  int rcnt  = 0;

  always #5 clk = ~clk;

  memory_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_DM_STREAK(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_abort(if_abort),
    .if_rdata(if_rdata), .if_valid(if_valid), .stall_F(stall_F),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_valid(dm_valid), .stall_M(stall_M),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  function automatic logic [31:0] mem_model(input logic [31:0] a);
    if (a == 32'h10) return 32'h00A00093;
    return a ^ 32'h5A5A_0000;
  endfunction

  // Memory answers in the lat-th cycle that mem_req is high.
  initial begin
    mem_ready = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (mem_req) begin
        rcnt++;
        if (rcnt == lat) begin
          mem_ready = 1'b1;
          mem_rdata = mem_model(mem_addr);
        end else begin
          mem_ready = 1'b0;
          mem_rdata = 32'hBAD0_BAD0;
        end
      end else begin
        rcnt      = 0;
        mem_ready = 1'b0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic        is_dm;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          lat;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[6];

  task automatic run_vec(input vec_t v, input int idx);
    logic        a_vld, a_stl, o_vld;
    logic [31:0] a_rd;
    @(negedge clk);
    lat = v.lat;
    if (v.is_dm) begin
      dm_req = 1'b1; dm_we = v.we; dm_addr = v.addr; dm_wdata = v.wdata;
    end else begin
      if_req = 1'b1; if_addr = v.addr;
    end
    #1;
    chk($sformatf("v%0d_stall_c0", idx), v.is_dm ? stall_M : stall_F, 1);
    for (int c = 1; c <= v.lat + 2; c++) begin
      @(negedge clk);
      a_vld = v.is_dm ? dm_valid : if_valid;
      a_stl = v.is_dm ? stall_M  : stall_F;
      a_rd  = v.is_dm ? dm_rdata : if_rdata;
      o_vld = v.is_dm ? if_valid : dm_valid;
      chk($sformatf("v%0d_other_valid_c%0d", idx, c), o_vld, 0);
      if (c <= v.lat) begin
        chk($sformatf("v%0d_mem_req_c%0d", idx, c), mem_req, 1);
        chk($sformatf("v%0d_mem_addr_c%0d", idx, c), mem_addr, v.addr);
        chk($sformatf("v%0d_mem_we_c%0d", idx, c), mem_we, v.is_dm & v.we);
        if (v.is_dm) chk($sformatf("v%0d_mem_wdata_c%0d", idx, c), mem_wdata, v.wdata);
        chk($sformatf("v%0d_valid_early_c%0d", idx, c), a_vld, 0);
        chk($sformatf("v%0d_stall_c%0d", idx, c), a_stl, 1);
      end else if (c == v.lat + 1) begin
        chk($sformatf("v%0d_valid", idx), a_vld, 1);
        chk($sformatf("v%0d_rdata", idx), a_rd, v.exp_rdata);
        chk($sformatf("v%0d_stall_at_valid", idx), a_stl, 0);
        chk($sformatf("v%0d_mem_req_at_valid", idx), mem_req, 0);
      end else begin
        // req was still high through the valid cycle; no second access may start
        chk($sformatf("v%0d_no_regrant", idx), mem_req, 0);
        chk($sformatf("v%0d_single_pulse", idx), a_vld, 0);
        if_req = 1'b0;
        dm_req = 1'b0;
      end
    end
  endtask

  initial begin
    int dm_cnt, if_cnt, first, dm_cyc, if_cyc, dm_done, if_done, dm_before;
    logic [31:0] cur;

    vecs[0] = '{1'b0, 1'b0, 32'h0000_0010, 32'h0,         2, 32'h00A0_0093};
    vecs[1] = '{1'b1, 1'b0, 32'h0000_0200, 32'h0,         1, 32'h5A5A_0200};
    vecs[2] = '{1'b1, 1'b1, 32'h0000_0040, 32'hDEAD_BEEF, 3, 32'h5A5A_0200};
    vecs[3] = '{1'b0, 1'b0, 32'h0000_0014, 32'h0,         4, 32'h5A5A_0014};
    vecs[4] = '{1'b1, 1'b0, 32'h0000_0044, 32'h0,         2, 32'h5A5A_0044};
    vecs[5] = '{1'b1, 1'b1, 32'h0000_0048, 32'h1234_5678, 1, 32'h5A5A_0044};

    rst_n = 1'b0;
    if_req = 1'b0; if_addr = '0; if_abort = 1'b0;
    dm_req = 1'b0; dm_we = 1'b0; dm_addr = '0; dm_wdata = '0;
    repeat (3) @(negedge clk);
    chk("rst_mem_req",   mem_req,   0);
    chk("rst_mem_we",    mem_we,    0);
    chk("rst_mem_addr",  mem_addr,  0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_if_valid",  if_valid,  0);
    chk("rst_dm_valid",  dm_valid,  0);
    chk("rst_if_rdata",  if_rdata,  0);
    chk("rst_dm_rdata",  dm_rdata,  0);
    chk("rst_stall_F",   stall_F,   0);
    chk("rst_stall_M",   stall_M,   0);
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

    // Simultaneous requests: DM first, then IF, one pulse each.
    @(negedge clk);
    lat = 1;
    if_req = 1'b1; if_addr = 32'h30;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h200;
    dm_cnt = 0; if_cnt = 0; first = -1; dm_cyc = -1; if_cyc = -1;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (if_req && !if_valid) chk($sformatf("sim_stall_F_c%0d", c), stall_F, 1);
      if (dm_valid) begin
        dm_cnt++; dm_cyc = c;
        if (first < 0) first = 0;
        chk("sim_dm_rdata", dm_rdata, 32'h5A5A_0200);
        dm_req = 1'b0;
      end
      if (if_valid) begin
        if_cnt++; if_cyc = c;
        if (first < 0) first = 1;
        chk("sim_if_rdata", if_rdata, 32'h5A5A_0030);
        if_req = 1'b0;
      end
    end
    chk("sim_dm_pulses", dm_cnt, 1);
    chk("sim_if_pulses", if_cnt, 1);
    chk("sim_dm_first",  first, 0);
    chk("sim_dm_cycle",  dm_cyc, 2);
    chk("sim_if_cycle",  if_cyc, 4);

    // Continuous loads with fetch waiting: fetch must get through within the streak bound.
    @(negedge clk);
    lat = 1;
    cur = 32'h400;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = cur;
    if_req = 1'b1; if_addr = 32'h20;
    dm_done = 0; if_done = 0; dm_before = 0;
    for (int c = 1; c <= 80 && !(dm_done >= 6 && if_done >= 1); c++) begin
      @(negedge clk);
      chk($sformatf("starve_no_overlap_c%0d", c), dm_valid & if_valid, 0);
      if (dm_valid) begin
        chk($sformatf("starve_dm_rdata_%0d", dm_done), dm_rdata, mem_model(cur));
        dm_done++;
        cur = cur + 32'd4;
        dm_addr = cur;
        if (dm_done == 6) dm_req = 1'b0;
      end
      if (if_valid) begin
        chk("starve_if_rdata", if_rdata, 32'h5A5A_0020);
        if (if_done == 0) dm_before = dm_done;
        if_done++;
        if_req = 1'b0;
      end
    end
    chk("starve_if_count", if_done, 1);
    chk("starve_dm_count", dm_done, 6);
    chk("starve_dm_first", dm_before >= 1, 1);
    chk("starve_bound",    dm_before <= 4, 1);
    chk("starve_dm_resumes", dm_done > dm_before, 1);
    dm_req = 1'b0; if_req = 1'b0;
    repeat (2) @(negedge clk);

    // Aborted fetch: access runs to mem_ready, no pulse, then the redirected fetch proceeds.
    lat = 3;
    if_req = 1'b1; if_addr = 32'h80;
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      if (c <= 3) chk($sformatf("abort_mem_req_c%0d", c), mem_req, 1);
      if (c <= 5) chk($sformatf("abort_no_valid_c%0d", c), if_valid, 0);
      if (c == 2) begin
        if_abort = 1'b1;
        if_addr  = 32'h90;
      end
      if (c == 3) if_abort = 1'b0;
      if (c == 4) begin
        chk("abort_rdata_kept", if_rdata, 32'h5A5A_0020);
        lat = 1;
      end
      if (c == 5) begin
        chk("abort_regrant_req",  mem_req,  1);
        chk("abort_regrant_addr", mem_addr, 32'h90);
      end
      if (c == 6) begin
        chk("abort_next_valid", if_valid, 1);
        chk("abort_next_rdata", if_rdata, 32'h5A5A_0090);
        if_req = 1'b0;
      end
      if (c == 7) chk("abort_next_single", if_valid, 0);
    end

    // Reset during a data access.
    @(negedge clk);
    lat = 5;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h300;
    repeat (2) @(negedge clk);
    chk("rmid_busy", mem_req, 1);
    rst_n = 1'b0;
    #1;
    chk("rmid_mem_req",  mem_req,  0);
    chk("rmid_mem_addr", mem_addr, 0);
    chk("rmid_dm_valid", dm_valid, 0);
    chk("rmid_dm_rdata", dm_rdata, 0);
    chk("rmid_if_rdata", if_rdata, 0);
    dm_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk($sformatf("rmid_no_valid_%0d", c), dm_valid, 0);
      chk($sformatf("rmid_idle_%0d", c), mem_req, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
